// File: rtl/bilinear_interp_axis.sv
// Multi-channel bilinear interpolator, 4-stage AXI4-Stream pipeline.
// Macro BILINEAR_ROUND_EN: round half-up at output (default truncate).
module bilinear_interp_axis #(
  parameter int NCH = 2,
  parameter int NPPC = 4,
  parameter int BPP = 8,
  parameter int PREC = 8,
  parameter logic [BPP-1:0] OOB_VALUE = '0
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic [NCH*NPPC*BPP-1:0]  s_axis_p00,
  input  logic [NCH*NPPC*BPP-1:0]  s_axis_p01,
  input  logic [NCH*NPPC*BPP-1:0]  s_axis_p10,
  input  logic [NCH*NPPC*BPP-1:0]  s_axis_p11,
  input  logic [NCH*NPPC*PREC-1:0] s_axis_fx,
  input  logic [NCH*NPPC*PREC-1:0] s_axis_fy,
  input  logic [NCH*NPPC-1:0]      s_axis_oob,
  input  logic                     s_axis_tlast,
  input  logic                     s_axis_tuser,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [NCH*NPPC*BPP-1:0]  m_axis_tdata,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tuser
);

  localparam int L  = NCH * NPPC;
  localparam int WW = PREC + 1;
  localparam int PW = BPP + PREC + 1;
  localparam int VW = BPP + 2 * PREC + 2;
  localparam int QW = VW - 2 * PREC;
  localparam logic [WW-1:0] ONE = WW'(1) << PREC;
`ifdef BILINEAR_ROUND_EN
  localparam logic [VW-1:0] RND = VW'(1) << (2 * PREC - 1);
`else
  localparam logic [VW-1:0] RND = '0;
`endif

  logic v1_q, v2_q, v3_q, v4_q;
  logic v1_d, v2_d, v3_d, v4_d;
  logic ld1, ld2, ld3, ld4, adv4;

  logic [L-1:0][PW-1:0]   a00_q, a01_q, a10_q, a11_q;
  logic [L-1:0][PW-1:0]   a00_d, a01_d, a10_d, a11_d;
  logic [L-1:0][PREC-1:0] fy1_q, fy2_q;
  logic [L-1:0]           oob1_q, oob2_q, oob3_q;
  logic                   last1_q, last2_q, last3_q, last4_q;
  logic                   user1_q, user2_q, user3_q, user4_q;
  logic [L-1:0][PW-1:0]   h0_q, h1_q, h0_d, h1_d;
  logic [L-1:0][VW-1:0]   vv_q, vv_d, rs;
  logic [L-1:0][QW-1:0]   qf;
  logic [L-1:0][BPP-1:0]  q_d;
  logic [L*BPP-1:0]       tdata_q;
  logic [L-1:0][WW-1:0]   wx0, wx1, wy0, wy1;

  // Backpressure: each stage loads when empty or when it drains this cycle
  always_comb begin
    adv4 = v4_q & m_axis_tready;
    ld4 = v3_q & (!v4_q | m_axis_tready);
    ld3 = v2_q & (!v3_q | ld4);
    ld2 = v1_q & (!v2_q | ld3);
    s_axis_tready = aresetn & (!v1_q | ld2);
    ld1 = s_axis_tvalid & s_axis_tready;
    v1_d = ld1 | (v1_q & !ld2);
    v2_d = ld2 | (v2_q & !ld3);
    v3_d = ld3 | (v3_q & !ld4);
    v4_d = ld4 | (v4_q & !adv4);
  end

  // Per-lane datapath: products, horizontal sums, vertical blend, output
  always_comb begin
    wx0 = '0;
    wx1 = '0;
    wy0 = '0;
    wy1 = '0;
    a00_d = '0;
    a01_d = '0;
    a10_d = '0;
    a11_d = '0;
    h0_d = '0;
    h1_d = '0;
    vv_d = '0;
    rs = '0;
    qf = '0;
    q_d = '0;
    for (int k = 0; k < L; k++) begin
      wx1[k] = {1'b0, s_axis_fx[k*PREC +: PREC]};
      wx0[k] = ONE - wx1[k];
      a00_d[k] = PW'(wx0[k]) * PW'(s_axis_p00[k*BPP +: BPP]);
      a01_d[k] = PW'(wx1[k]) * PW'(s_axis_p01[k*BPP +: BPP]);
      a10_d[k] = PW'(wx0[k]) * PW'(s_axis_p10[k*BPP +: BPP]);
      a11_d[k] = PW'(wx1[k]) * PW'(s_axis_p11[k*BPP +: BPP]);
      h0_d[k] = a00_q[k] + a01_q[k];
      h1_d[k] = a10_q[k] + a11_q[k];
      wy1[k] = {1'b0, fy2_q[k]};
      wy0[k] = ONE - wy1[k];
      vv_d[k] = VW'(wy0[k]) * VW'(h0_q[k])
              + VW'(wy1[k]) * VW'(h1_q[k]);
      rs[k] = vv_q[k] + RND;
      qf[k] = rs[k][VW-1:2*PREC];
      if (|qf[k][QW-1:BPP]) q_d[k] = '1;
      else q_d[k] = qf[k][BPP-1:0];
      if (oob3_q[k]) q_d[k] = OOB_VALUE;
    end
  end

  // Stage valids and the output register, cleared by reset
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      v4_q <= 1'b0;
      tdata_q <= '0;
      last4_q <= 1'b0;
      user4_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      v4_q <= v4_d;
      if (ld4) begin
        for (int k = 0; k < L; k++) tdata_q[k*BPP +: BPP] <= q_d[k];
        last4_q <= last3_q;
        user4_q <= user3_q;
      end
    end
  end

  // Internal stage payloads; qualified by the valid bits only
  always_ff @(posedge aclk) begin
    if (ld1) begin
      a00_q <= a00_d;
      a01_q <= a01_d;
      a10_q <= a10_d;
      a11_q <= a11_d;
      fy1_q <= s_axis_fy;
      oob1_q <= s_axis_oob;
      last1_q <= s_axis_tlast;
      user1_q <= s_axis_tuser;
    end
    if (ld2) begin
      h0_q <= h0_d;
      h1_q <= h1_d;
      fy2_q <= fy1_q;
      oob2_q <= oob1_q;
      last2_q <= last1_q;
      user2_q <= user1_q;
    end
    if (ld3) begin
      vv_q <= vv_d;
      oob3_q <= oob2_q;
      last3_q <= last2_q;
      user3_q <= user2_q;
    end
  end

  assign m_axis_tvalid = v4_q;
  assign m_axis_tdata = tdata_q;
  assign m_axis_tlast = last4_q;
  assign m_axis_tuser = user4_q;

endmodule

// File: tb/tb_bilinear_interp_axis.sv
// Scoreboard bench for bilinear_interp_axis at default parameters.
// Honours BILINEAR_ROUND_EN for the rounding-dependent vectors.
module tb_bilinear_interp_axis;

  localparam int L = 8;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [63:0] s_p00 = '0, s_p01 = '0, s_p10 = '0, s_p11 = '0;
  logic [63:0] s_fx = '0, s_fy = '0;
  logic [7:0]  s_oob = '0;
  logic        s_tlast = 1'b0, s_tuser = 1'b0;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic [63:0] m_tdata;
  logic        m_tlast, m_tuser;

  bilinear_interp_axis #(
    .NCH(2), .NPPC(4), .BPP(8), .PREC(8), .OOB_VALUE(8'd0)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_p00(s_p00),
    .s_axis_p01(s_p01),
    .s_axis_p10(s_p10),
    .s_axis_p11(s_p11),
    .s_axis_fx(s_fx),
    .s_axis_fy(s_fy),
    .s_axis_oob(s_oob),
    .s_axis_tlast(s_tlast),
    .s_axis_tuser(s_tuser),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tdata(m_tdata),
    .m_axis_tlast(m_tlast),
    .m_axis_tuser(m_tuser)
  );

  typedef struct {
    logic [63:0] d;
    logic        l;
    logic        u;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int inflight = 0;
  logic held_v = 1'b0;
  logic [65:0] held = '0;
  bit stream_done = 0;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [63:0] rep(input logic [7:0] v);
    return {8{v}};
  endfunction

  function automatic logic [7:0] lane_q(input longint a, b, c, d,
                                        input longint fx, fy,
                                        input bit oob);
    longint s, v;
    s = 256;
    v = a * (s - fx) * (s - fy) + b * fx * (s - fy)
      + c * (s - fx) * fy + d * fx * fy;
`ifdef BILINEAR_ROUND_EN
    v = v + 32768;
`endif
    v = v >>> 16;
    if (v > 255) v = 255;
    if (oob) v = 0;
    return 8'(v);
  endfunction

  // Monitor: pops the scoreboard on every output handshake
  always @(negedge aclk) begin
    exp_t e;
    if (!aresetn) begin
      inflight = 0;
      held_v = 1'b0;
    end else begin
      if (held_v)
        chk("stable", 128'({m_tvalid, m_tlast, m_tuser, m_tdata}),
            128'({1'b1, held}));
      chk("ready_rule", 128'(s_tready),
          128'(!(inflight == 4 && !m_tready)));
      if (m_tvalid && m_tready) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat actual=%0h required=none", m_tdata);
        end else begin
          e = sbq.pop_front();
          chk("beat", 128'({m_tlast, m_tuser, m_tdata}),
              128'({e.l, e.u, e.d}));
          if (e.lat != 0)
            chk("latency", 128'(cyc - e.acc), 128'(e.lat));
        end
      end
      held_v = m_tvalid && !m_tready;
      held = {m_tlast, m_tuser, m_tdata};
      inflight = inflight + int'(s_tvalid && s_tready)
               - int'(m_tvalid && m_tready);
    end
  end

  task automatic send(input logic [63:0] a, b, c, d, fx, fy,
                      input logic [7:0] oob, input logic l, u,
                      input logic [63:0] ex, input int lat);
    int n = 0;
    bit done = 0;
    s_p00 = a;
    s_p01 = b;
    s_p10 = c;
    s_p11 = d;
    s_fx = fx;
    s_fy = fy;
    s_oob = oob;
    s_tlast = l;
    s_tuser = u;
    s_tvalid = 1'b1;
    while (!done) begin
      @(negedge aclk);
      if (s_tready) begin
        sbq.push_back('{ex, l, u, cyc, lat});
        done = 1;
      end
      @(posedge aclk);
      #1;
      n++;
      if (!done && n > 200) begin
        total++;
        bad++;
        $display("FAIL send_timeout actual=%0d required=accept", n);
        done = 1;
      end
    end
    s_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 300) begin
      @(posedge aclk);
      #1;
      n++;
    end
    chk("drain", 128'(sbq.size()), 128'(0));
  endtask

  logic [63:0] ra[20], rb[20], rc[20], rd[20], rfx[20], rfy[20], rex[20];
  logic [7:0]  roob[20];

  task automatic run_stream();
    for (int i = 0; i < 20; i++)
      send(ra[i], rb[i], rc[i], rd[i], rfx[i], rfy[i], roob[i],
           (i % 5) == 4, i == 0, rex[i], 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] t6;
    for (int i = 0; i < 20; i++) begin
      ra[i] = {$urandom, $urandom};
      rb[i] = {$urandom, $urandom};
      rc[i] = {$urandom, $urandom};
      rd[i] = {$urandom, $urandom};
      rfx[i] = {$urandom, $urandom};
      rfy[i] = {$urandom, $urandom};
      roob[i] = 8'($urandom);
      for (int k = 0; k < L; k++)
        rex[i][k*8 +: 8] = lane_q(longint'(ra[i][k*8 +: 8]),
                                  longint'(rb[i][k*8 +: 8]),
                                  longint'(rc[i][k*8 +: 8]),
                                  longint'(rd[i][k*8 +: 8]),
                                  longint'(rfx[i][k*8 +: 8]),
                                  longint'(rfy[i][k*8 +: 8]),
                                  roob[i][k]);
    end

    repeat (2) @(posedge aclk);
    @(negedge aclk);
    chk("rst_tvalid", 128'(m_tvalid), 128'(0));
    chk("rst_tdata", 128'(m_tdata), 128'(0));
    chk("rst_tlast", 128'(m_tlast), 128'(0));
    chk("rst_tuser", 128'(m_tuser), 128'(0));
    chk("rst_tready", 128'(s_tready), 128'(0));
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    send(rep(10), rep(20), rep(0), rep(0), rep(128), rep(0),
         8'h00, 1'b1, 1'b1, rep(15), 4);
    drain();
`ifdef BILINEAR_ROUND_EN
    send(rep(0), rep(0), rep(0), rep(255), rep(128), rep(128),
         8'h00, 1'b0, 1'b0, rep(64), 4);
    t6 = rep(88);
`else
    send(rep(0), rep(0), rep(0), rep(255), rep(128), rep(128),
         8'h00, 1'b0, 1'b0, rep(63), 4);
    t6 = rep(87);
`endif
    send(rep(255), rep(255), rep(255), rep(255),
         {$urandom, $urandom}, {$urandom, $urandom},
         8'h00, 1'b1, 1'b0, rep(255), 4);
    send(rep(10), rep(20), rep(0), rep(0), rep(128), rep(0),
         8'b0010_1000, 1'b0, 1'b1, 64'h0F0F_000F_000F_0F0F, 4);
    send(64'h1122_3344_5566_7788, rep(255), rep(255), rep(255),
         rep(0), rep(0), 8'h00, 1'b1, 1'b1, 64'h1122_3344_5566_7788, 4);
    send(rep(100), rep(200), rep(50), rep(150), rep(64), rep(192),
         8'h00, 1'b0, 1'b0, t6, 4);
    drain();

    send(rep(1), rep(2), rep(3), rep(4), rep(9), rep(9),
         8'h00, 1'b0, 1'b0, rep(1), 0);
    send(rep(5), rep(6), rep(7), rep(8), rep(9), rep(9),
         8'h00, 1'b0, 1'b0, rep(5), 0);
    send(rep(9), rep(9), rep(9), rep(9), rep(9), rep(9),
         8'h00, 1'b0, 1'b0, rep(9), 0);
    aresetn = 1'b0;
    sbq.delete();
    @(negedge aclk);
    chk("rst_mid_tready", 128'(s_tready), 128'(0));
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    chk("rst_mid_tvalid", 128'(m_tvalid), 128'(0));
    chk("rst_mid_tdata", 128'(m_tdata), 128'(0));
    send(rep(10), rep(20), rep(0), rep(0), rep(128), rep(0),
         8'h00, 1'b1, 1'b0, rep(15), 4);
    drain();

    run_stream();
    drain();

    fork
      begin
        run_stream();
        stream_done = 1;
      end
      begin
        int ph = 0;
        while (!stream_done) begin
          m_tready = (ph >= 3);
          ph = (ph + 1) % 5;
          @(posedge aclk);
          #1;
        end
        m_tready = 1'b1;
      end
    join
    drain();

    repeat (4) @(posedge aclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
